// File: rtl/dmac_nch.sv
// rtl/dmac_nch.sv - N-channel fly-by DMA controller with fixed or rotating priority
module dmac_nch #(
    parameter int NCH    = 4,
    parameter int AW     = 16,
    parameter bit ROTATE = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    REGW,
    input  logic [$clog2(NCH)-1:0]  CHSEL,
    input  logic [1:0]              REGSEL,
    input  logic [AW-1:0]           Setup,
    input  logic [NCH-1:0]          DREQ,
    input  logic                    HLDA,
    input  logic                    RDY,
    output logic                    HLD,
    output logic [NCH-1:0]          DACK,
    output logic [AW-1:0]           Addrbus,
    output logic                    MEMR,
    output logic                    MEMW,
    output logic                    IOR,
    output logic                    IOW,
    output logic                    EOP,
    output logic [NCH-1:0]          TC
);
    localparam int CW = $clog2(NCH);
    localparam logic [AW-1:0]  ONE  = 1;
    localparam logic [NCH-1:0] ONEH = 1;

    typedef enum logic [2:0] {IDLE, REQ, S1, XFER, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   basea [NCH];
    logic [AW-1:0]   cura  [NCH];
    logic [AW-1:0]   basec [NCH];
    logic [AW-1:0]   curc  [NCH];
    logic [5:0]      mode  [NCH];
    logic [CW-1:0]   ch, rot, win, rot_next;
    logic            found;
    logic [AW-1:0]   nxt_addr;
    logic [1:0]      xmode;

    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NCH) s = s - NCH;
        return s[CW-1:0];
    endfunction

    // Scan from lowest priority upward so the highest-priority eligible channel wins last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (DREQ[wrap_add(rot, i)] && mode[wrap_add(rot, i)][5]) begin
                found = 1'b1;
                win   = wrap_add(rot, i);
            end
        end
    end

    always_comb begin
        rot_next = ROTATE ? wrap_add(ch, 1) : '0;
        xmode    = mode[ch][1:0];
        nxt_addr = mode[ch][3] ? cura[ch] - ONE : cura[ch] + ONE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            ch      <= '0;
            rot     <= '0;
            TC      <= '0;
            HLD     <= 1'b0;
            DACK    <= '0;
            Addrbus <= '0;
            MEMR    <= 1'b0;
            MEMW    <= 1'b0;
            IOR     <= 1'b0;
            IOW     <= 1'b0;
            EOP     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                basea[i] <= '0;
                cura[i]  <= '0;
                basec[i] <= '0;
                curc[i]  <= '0;
                mode[i]  <= '0;
            end
        end else begin
            EOP <= 1'b0;
            case (state)
                IDLE: begin
                    if (REGW) begin
                        if (int'(CHSEL) < NCH) begin
                            case (REGSEL)
                                2'b00: begin basea[CHSEL] <= Setup; cura[CHSEL] <= Setup; end
                                2'b01: begin basec[CHSEL] <= Setup; curc[CHSEL] <= Setup; end
                                2'b11: begin mode[CHSEL] <= Setup[5:0]; TC[CHSEL] <= 1'b0; end
                                default: ;
                            endcase
                        end
                    end else if (found) begin
                        ch    <= win;
                        HLD   <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (HLDA) begin
                        state   <= S1;
                        DACK    <= ONEH << ch;
                        Addrbus <= cura[ch];
                    end
                end
                S1: begin
                    if (!HLDA) begin
                        state   <= IDLE;
                        HLD     <= 1'b0;
                        DACK    <= '0;
                        Addrbus <= '0;
                        rot     <= rot_next;
                    end else begin
                        state <= XFER;
                        MEMR  <= mode[ch][2];
                        IOW   <= mode[ch][2];
                        IOR   <= !mode[ch][2];
                        MEMW  <= !mode[ch][2];
                    end
                end
                XFER: begin
                    if (!HLDA) begin
                        state   <= IDLE;
                        HLD     <= 1'b0;
                        DACK    <= '0;
                        Addrbus <= '0;
                        {MEMR, MEMW, IOR, IOW} <= 4'b0000;
                        rot     <= rot_next;
                    end else if (RDY) begin
                        state <= DONE;
                        {MEMR, MEMW, IOR, IOW} <= 4'b0000;
                        EOP   <= (curc[ch] == '0);
                    end
                end
                DONE: begin
                    // Continuing into S1 keeps DACK/HLD asserted; every other exit releases the bus.
                    if (curc[ch] == '0) begin
                        TC[ch] <= 1'b1;
                        if (mode[ch][4]) begin
                            cura[ch] <= basea[ch];
                            curc[ch] <= basec[ch];
                        end else begin
                            mode[ch][5] <= 1'b0;
                        end
                        state   <= IDLE;
                        HLD     <= 1'b0;
                        DACK    <= '0;
                        Addrbus <= '0;
                        rot     <= rot_next;
                    end else begin
                        curc[ch] <= curc[ch] - ONE;
                        cura[ch] <= nxt_addr;
                        if (HLDA && (xmode == 2'b01 || (xmode == 2'b10 && DREQ[ch]))) begin
                            state   <= S1;
                            Addrbus <= nxt_addr;
                        end else begin
                            state   <= IDLE;
                            HLD     <= 1'b0;
                            DACK    <= '0;
                            Addrbus <= '0;
                            rot     <= rot_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmac_nch.sv
// tb/tb_dmac_nch.sv - directed table-driven bench for dmac_nch
module tb_dmac_nch;
    logic        clk = 1'b0, rst_n = 1'b0, regw = 1'b0, hlda = 1'b1, rdy = 1'b1;
    logic [1:0]  chsel = '0, regsel = '0;
    logic [15:0] setup = '0;
    logic [3:0]  dreq = '0;

    logic        hld0, memr0, memw0, ior0, iow0, eop0;
    logic [3:0]  dack0, tc0;
    logic [15:0] addr0;
    logic        hld1, memr1, memw1, ior1, iow1, eop1;
    logic [3:0]  dack1, tc1;
    logic [15:0] addr1;

    int n_cmp = 0, n_err = 0;

    dmac_nch #(.NCH(4), .AW(16), .ROTATE(1'b0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .REGW(regw), .CHSEL(chsel), .REGSEL(regsel), .Setup(setup),
        .DREQ(dreq), .HLDA(hlda), .RDY(rdy), .HLD(hld0), .DACK(dack0), .Addrbus(addr0),
        .MEMR(memr0), .MEMW(memw0), .IOR(ior0), .IOW(iow0), .EOP(eop0), .TC(tc0));

    dmac_nch #(.NCH(4), .AW(16), .ROTATE(1'b1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .REGW(regw), .CHSEL(chsel), .REGSEL(regsel), .Setup(setup),
        .DREQ(dreq), .HLDA(hlda), .RDY(rdy), .HLD(hld1), .DACK(dack1), .Addrbus(addr1),
        .MEMR(memr1), .MEMW(memw1), .IOR(ior1), .IOW(iow1), .EOP(eop1), .TC(tc1));

    always #5 clk = ~clk;

    bit          mon = 1'b0, rot_mon = 1'b0;
    logic        prev_stb = 1'b0;
    logic [3:0]  prev_dk0 = '0, prev_dk1 = '0;
    logic [15:0] xa[$];
    logic [3:0]  xs[$];
    logic [3:0]  xd[$];
    logic [3:0]  dk0[$];
    logic [3:0]  dk1[$];
    int          ndack = 0;

    always @(negedge clk) begin
        if (mon) begin
            if ((ior0 | memr0) && !prev_stb) begin
                xa.push_back(addr0);
                xs.push_back({memr0, memw0, ior0, iow0});
                xd.push_back(dack0);
            end
            if (dack0 != 4'd0) ndack++;
        end
        if (rot_mon) begin
            if (dack0 != 4'd0 && prev_dk0 == 4'd0) dk0.push_back(dack0);
            if (dack1 != 4'd0 && prev_dk1 == 4'd0) dk1.push_back(dack1);
        end
        prev_stb = ior0 | memr0;
        prev_dk0 = dack0;
        prev_dk1 = dack1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int c, input logic [1:0] s, input logic [15:0] d);
        regw = 1'b1; chsel = c[1:0]; regsel = s; setup = d;
        tick();
        regw = 1'b0;
    endtask

    task automatic prog(input int c, input logic [15:0] a, input logic [15:0] n, input logic [5:0] m);
        wr(c, 2'b00, a);
        wr(c, 2'b01, n);
        wr(c, 2'b11, {10'd0, m});
    endtask

    task automatic wait_release(input string nm);
        int k = 0;
        while ((hld0 || hld1) && k < 50) begin tick(); k++; end
        check({nm, "_hld_release"}, 32'({hld0, hld1}), 0);
    endtask

    typedef struct {
        int          ch;
        logic [15:0] addr;
        logic [15:0] cnt;
        logic [5:0]  mode;
        int          n;
        int          first;
        int          last;
        logic [3:0]  stb;
        int          cura;
        int          curc;
        int          en;
    } vec_t;

    vec_t tv[5];

    initial begin
        int k, nr, nh, c;
        logic pi;

        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nr, nh, c;
        logic pi;

        tv[0] = '{0, 16'h00CC, 16'd3, 6'h21, 4, 'h00CC, 'h00CF, 4'b0110, 'h00CF, 0, 0};
        tv[1] = '{1, 16'h0100, 16'd1, 6'h3D, 2, 'h0100, 'h00FF, 4'b1001, 'h0100, 1, 1};
        tv[2] = '{3, 16'hFFFF, 16'd2, 6'h21, 3, 'hFFFF, 'h0001, 4'b0110, 'h0001, 0, 0};
        tv[3] = '{2, 16'h0010, 16'd0, 6'h27, 1, 'h0010, 'h0010, 4'b1001, 'h0010, 0, 0};
        tv[4] = '{3, 16'h0005, 16'd2, 6'h39, 3, 'h0005, 'h0003, 4'b0110, 'h0005, 2, 1};

        tick(); tick();
        check("reset_outputs", 32'({hld0, dack0, addr0, memr0, memw0, ior0, iow0, eop0, tc0}), 0);
        rst_n = 1'b1;
        tick();

        // Single transfer latency: HLD, then DACK, then strobe, then DONE with EOP.
        prog(0, 16'h0042, 16'd0, 6'h20);
        dreq = 4'b0001;
        tick();
        check("lat_hld", 32'({hld0, dack0}), 32'h10);
        tick();
        check("lat_s1", 32'({dack0, addr0, ior0, memw0}), 32'({4'b0001, 16'h0042, 2'b00}));
        tick();
        check("lat_strobe", 32'({memr0, memw0, ior0, iow0}), 32'b0110);
        tick();
        check("lat_done", 32'({dack0, eop0, ior0, memw0}), 32'({4'b0001, 3'b100}));
        dreq = 4'b0000;
        tick();
        check("lat_release", 32'({hld0, dack0, eop0, addr0, tc0}), 32'({1'b0, 4'b0, 1'b0, 16'h0, 4'b0001}));
        wr(0, 2'b11, 16'h0020);
        check("mode_clears_tc", 32'(tc0), 0);

        for (int i = 0; i < 5; i++) begin
            c = tv[i].ch;
            prog(c, tv[i].addr, tv[i].cnt, tv[i].mode);
            xa.delete(); xs.delete(); xd.delete();
            ndack = 0;
            mon = 1'b1;
            dreq = 4'(1 << c);
            k = 0;
            while (!eop0 && k < 100) begin tick(); k++; end
            check($sformatf("v%0d_eop", i), 32'(eop0), 1);
            dreq = 4'b0000;
            wait_release($sformatf("v%0d", i));
            tick();
            mon = 1'b0;
            check($sformatf("v%0d_nxfer", i), 32'(xa.size()), 32'(tv[i].n));
            check($sformatf("v%0d_first", i), (xa.size() > 0) ? 32'(xa[0]) : 32'hDEADBEEF, 32'(tv[i].first));
            check($sformatf("v%0d_last", i), (xa.size() > 0) ? 32'(xa[xa.size()-1]) : 32'hDEADBEEF, 32'(tv[i].last));
            check($sformatf("v%0d_strobes", i), (xs.size() > 0) ? 32'(xs[0]) : 32'hDEADBEEF, 32'(tv[i].stb));
            check($sformatf("v%0d_dack", i), (xd.size() > 0) ? 32'(xd[0]) : 32'hDEADBEEF, 32'(1 << c));
            check($sformatf("v%0d_dack_cycles", i), 32'(ndack), 32'(3 * tv[i].n));
            check($sformatf("v%0d_cura", i), 32'(dut0.cura[c]), 32'(tv[i].cura));
            check($sformatf("v%0d_curc", i), 32'(dut0.curc[c]), 32'(tv[i].curc));
            check($sformatf("v%0d_enable", i), 32'(dut0.mode[c][5]), 32'(tv[i].en));
            check($sformatf("v%0d_tc", i), 32'(tc0[c]), 1);
        end

        // Demand mode: DREQ drops during the second transfer.
        prog(2, 16'h0200, 16'd5, 6'h22);
        dreq = 4'b0100;
        k = 0; nr = 0; pi = 1'b0;
        while (nr < 2 && k < 100) begin
            tick(); k++;
            if (ior0 && !pi) nr++;
            pi = ior0;
        end
        dreq = 4'b0000;
        wait_release("dem_pause");
        check("dem_curc_pause", 32'(dut0.curc[2]), 3);
        check("dem_cura_pause", 32'(dut0.cura[2]), 'h0202);
        check("dem_tc_pause", 32'(tc0[2]), 0);
        tick();
        dreq = 4'b0100;
        k = 0; nr = 0; pi = 1'b0;
        while (!eop0 && k < 100) begin
            tick(); k++;
            if (ior0 && !pi) nr++;
            pi = ior0;
        end
        check("dem_eop", 32'(eop0), 1);
        check("dem_remaining", 32'(nr), 4);
        dreq = 4'b0000;
        wait_release("dem_end");
        check("dem_cura_end", 32'(dut0.cura[2]), 'h0205);
        check("dem_tc_end", 32'(tc0[2]), 1);
        tick();

        // Slave not ready for four XFER cycles.
        prog(2, 16'h0300, 16'd0, 6'h20);
        rdy = 1'b0;
        dreq = 4'b0100;
        k = 0;
        while (!ior0 && k < 20) begin tick(); k++; end
        check("rdy_strobe_rise", 32'(ior0), 1);
        nh = int'(ior0);
        for (int j = 0; j < 4; j++) begin tick(); nh += int'(ior0); end
        check("rdy_addr_hold", 32'(addr0), 'h0300);
        rdy = 1'b1;
        tick();
        check("rdy_done", 32'({ior0, eop0}), 32'b01);
        check("rdy_stretch", 32'(nh), 5);
        dreq = 4'b0000;
        wait_release("rdy");
        tick();

        // HLDA withdrawn mid-transfer.
        prog(2, 16'h0400, 16'd2, 6'h21);
        rdy = 1'b0;
        dreq = 4'b0100;
        k = 0;
        while (!ior0 && k < 20) begin tick(); k++; end
        check("abort_strobe_rise", 32'(ior0), 1);
        hlda = 1'b0;
        dreq = 4'b0000;
        tick();
        check("abort_outputs", 32'({hld0, dack0, memr0, memw0, ior0, iow0}), 0);
        check("abort_curc", 32'(dut0.curc[2]), 2);
        check("abort_cura", 32'(dut0.cura[2]), 'h0400);
        hlda = 1'b1;
        rdy = 1'b1;
        tick();

        // Fixed vs rotating priority with ch0 and ch2 both requesting.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        prog(0, 16'h0500, 16'h00FF, 6'h20);
        prog(2, 16'h0600, 16'h00FF, 6'h20);
        dk0.delete(); dk1.delete();
        rot_mon = 1'b1;
        dreq = 4'b0101;
        for (int j = 0; j < 40; j++) tick();
        dreq = 4'b0000;
        wait_release("rot");
        rot_mon = 1'b0;
        check("rot_count0", 32'(dk0.size() >= 4), 1);
        check("rot_count1", 32'(dk1.size() >= 4), 1);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("fixed_order%0d", j), (dk0.size() > j) ? 32'(dk0[j]) : 32'hDEADBEEF, 32'h1);
            check($sformatf("rot_order%0d", j), (dk1.size() > j) ? 32'(dk1[j]) : 32'hDEADBEEF,
                  (j % 2 == 0) ? 32'h1 : 32'h4);
        end
        tick();

        // Asynchronous reset during a block transfer.
        prog(0, 16'h00CC, 16'd3, 6'h21);
        dreq = 4'b0001;
        k = 0;
        while (!ior0 && k < 20) begin tick(); k++; end
        check("rstmid_strobe_rise", 32'(ior0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_outputs", 32'({hld0, dack0, addr0, memr0, memw0, ior0, iow0, eop0, tc0}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        check("rstmid_idle", 32'({hld0, dack0}), 0);
        check("rstmid_enable", 32'(dut0.mode[0][5]), 0);
        dreq = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmac_nch.md
# dmac_nch

Parametrised N-channel fly-by DMA controller, the next generation of the single-channel `DMAC`. Each channel owns base/current address and count registers and a mode register, and supports single, block and demand transfers in either direction. Channels can auto-initialise, and requests are arbitrated with fixed or rotating priority. The block sits between peripheral request lines and the system bus, borrowing the bus through HLD/HLDA and moving data directly between I/O and memory with no internal data path.

## Interface
- NCH, 4: channel count (2..8).
- AW, 16: address and count width.
- ROTATE, 0: 0 = fixed priority (ch0 highest); 1 = rotating priority.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- REGW  in  1  register write strobe.
- CHSEL  in  $clog2(NCH)  channel addressed by REGW.
- REGSEL  in  2  register select: 00 address, 01 count, 10 ignored, 11 mode.
- Setup  in  AW  write data.
- DREQ  in  NCH  per-channel request, level-sensitive.
- HLDA  in  1  bus hold acknowledge.
- RDY  in  1  slave ready; extends the strobe phase.
- HLD  out  1  bus hold request.
- DACK  out  NCH  one-hot acknowledge of the serviced channel.
- Addrbus  out  AW  current address of the active channel; 0 when no channel is active.
- MEMR, MEMW, IOR, IOW  out  1  bus strobes.
- EOP  out  1  one-cycle terminal-count pulse.
- TC  out  NCH  sticky terminal-count flags.

## Operation
- Per-channel state: BASEA, CURA, BASEC, CURC (AW bits each) and MODE[5:0].
- Address write loads BASEA and CURA. Count write loads BASEC and CURC.
- Mode write loads MODE and clears TC[ch].
- MODE fields:
  - [1:0] transfer mode: 00 single, 01 block, 10 demand, 11 treated as single.
  - [2] direction: 0 = I/O→mem (IOR+MEMW); 1 = mem→I/O (MEMR+IOW).
  - [3] address step: 0 = +1; 1 = −1.
  - [4] autoinit.
  - [5] enable.
- Transfers per programmed run = CURC+1. Address wraps modulo 2^AW.
- REGW is accepted only in IDLE. When REGW is high in IDLE, no arbitration occurs that cycle.
- A channel is eligible when DREQ[ch]=1 and MODE[5]=1.
- Fixed priority: lowest index wins.
- Rotating priority: the channel that last returned to IDLE becomes lowest priority; pointer resets to ch0 highest.
- FSM states:
  - IDLE: if any channel is eligible, latch the winner, set HLD=1, go to REQ.
  - REQ: hold until HLDA=1, then go to S1.
  - S1: DACK[ch]=1; Addrbus=CURA; strobes low. Go to XFER.
  - XFER: direction strobes high. Stay while RDY=0; RDY=1 goes to DONE.
  - DONE: strobes low; DACK still high.
    - If CURC==0: set TC[ch], pulse EOP. With autoinit, reload CURA/CURC from BASEA/BASEC; otherwise clear MODE[5]. Then drop HLD and go to IDLE.
    - Otherwise decrement CURC and step CURA, then:
      - single: drop HLD, go to IDLE.
      - block: go to S1.
      - demand: go to S1 if DREQ[ch]=1, else drop HLD and go to IDLE.
- Block mode ignores DREQ after the grant.
- HLDA falling in S1 or XFER: strobes and DACK drop next cycle, no register update, HLD=0, return to IDLE.
- HLDA falling in DONE: DONE completes normally, then the FSM returns to IDLE.

## Timing
- Reset (asynchronous): FSM=IDLE; all channel registers, TC and rotate pointer = 0; every output = 0.
- Latency from DREQ sampled in IDLE:
  - HLD high at the next edge.
  - With HLDA already high, S1 follows REQ by one cycle.
  - First strobe rises 3 cycles after DREQ is sampled.
- A transfer with RDY=1 takes 3 cycles (S1, XFER, DONE). A block of N transfers takes 3N cycles of DACK.
- Each cycle in XFER with RDY=0 adds one cycle.
- EOP is high for exactly the DONE cycle of the final transfer, concurrent with DACK.
- Updated CURA/CURC are visible from the cycle after DONE.
- After HLD drops, the FSM needs one IDLE cycle before any new arbitration.
- A request that arrives during another channel's service waits for IDLE; there is no preemption.

## Test plan
- Reset mid-block (RST_N low during XFER): all outputs 0 immediately; on release, the FSM idles with MODE enables cleared.
- ch0 programmed addr=0x00CC, count=3, mode=0x21 (block, I/O→mem, enable); DREQ[0]=1, HLDA=1, RDY=1:
  - Required: 4 IOR+MEMW strobes at 0x00CC..0x00CF.
  - EOP on the 4th DONE; TC[0]=1; MODE[5] cleared; HLD low afterwards.
- ch1 addr=0x0100, count=1, mode=0x3D (block, mem→I/O, decrement, autoinit, enable):
  - Required: MEMR+IOW at 0x0100 then 0x00FF, then EOP.
  - CURA/CURC reload to 0x0100/1 and the channel stays enabled.
- ch0 and ch2 both requesting in single mode:
  - ROTATE=0: ch0 serviced every time.
  - ROTATE=1: service alternates ch0, ch2, ch0…
- Demand mode, count=5: DREQ drops after 2 transfers.
  - Required: HLD releases and CURC=3.
  - Re-assert DREQ: the remaining 4 transfers complete with EOP.
- RDY held low 4 cycles in XFER: the strobe stretches to 5 cycles and the address holds.
- HLDA dropped during XFER: abort with CURC/CURA unchanged.
